sram1r1w_arbiter: RTL and testbench
===================================

Name: sram1r1w_arbiter

Overview:
Shares one 1R1W 512x32 SRAM macro between two requesters (client 0, client 1). Read and write ports are arbitered independently, each with its own round-robin pointer. The block drives the macro's chip-enable/address/data pins from the grants and returns read data on one shared response channel with valid/ready. Same-cycle read/write address collisions are forwarded, so a read always returns the newest data.

Parameters:
ADDR_W, 9, address width; macro depth is 2^ADDR_W
DATA_W, 32, data width

Ports:
clk  in  1  clock; also drives macro CE1/CE2
reset  in  1  synchronous, active-high
rd0_val / rd1_val  in  1  read request valid, client 0/1
rd0_addr / rd1_addr  in  ADDR_W  read address
rd0_rdy / rd1_rdy  out  1  read request accepted this cycle
wr0_val / wr1_val  in  1  write request valid
wr0_addr / wr1_addr  in  ADDR_W  write address
wr0_data / wr1_data  in  DATA_W  write data
wr0_rdy / wr1_rdy  out  1  write accepted this cycle
resp_val  out  1  read response valid
resp_id  out  1  client that issued the read
resp_data  out  DATA_W  read data
resp_rdy  in  1  response consumer ready
sram_a1  out  ADDR_W  macro read address
sram_csb1  out  1  macro read select, active-low
sram_oeb1  out  1  macro output enable, tied 0
sram_o1  in  DATA_W  macro read data
sram_a2  out  ADDR_W  macro write address
sram_csb2  out  1  macro write select, active-low
sram_web2  out  1  macro write enable, active-low
sram_i2  out  DATA_W  macro write data

Behaviour:
- Reset: resp_val=0, resp_id=0, forward flag=0, both round-robin pointers favour client 0. A response pending at reset is dropped. The macro outputs are combinational: during reset, csb1=csb2=web2=1 and all rdy=0.
- Read issue allowed (rd_en) = ~reset & (~resp_val | resp_rdy).
- Read arbitration when rd_en:
  - One valid requester: it wins.
  - Both valid: the pointer-favoured client wins, and the pointer then moves to the other client.
  - The pointer updates only on a contested grant.
- Read grant: rdN_rdy=1, sram_csb1=0, sram_a1 = winner address. The macro samples on the same clk edge.
- No read grant: sram_csb1=1 and the macro holds its output register.
- Write arbitration: independent round-robin with the same rules, but no back-pressure; a write is granted whenever ~reset.
- Write grant: wrN_rdy=1, sram_csb2=0, sram_web2=0, a2/i2 = winner address/data. Otherwise csb2=web2=1.
- Read latency: a read granted in cycle T drives resp_val=1 in T+1, with resp_id registered.
- Response hold: while resp_val & ~resp_rdy, resp_val/resp_id/resp_data are held stable. No new read is granted because rd_en=0. The macro output holds because csb1=1.
- Response retire: at resp_val & resp_rdy, a read granted in the same cycle replaces the response in the next cycle (back-to-back, full throughput). If no read is granted, resp_val drops.
- Collision: if a read and a write are granted in the same cycle to the same address, the macro returns old data. The block therefore registers fwd=1 and fwd_data = write data, and resp_data = fwd ? fwd_data : sram_o1.
  - fwd and fwd_data update only on a read grant.
- Write in T, read of the same address in T+1: no forwarding needed; the macro already holds the new data.
- Same client issuing read and write together: legal, subject to the collision rule.
- Address widths are unsigned with no wrap logic; all 2^ADDR_W locations are valid.

Test Plan:
- After reset, a write from client 0 to addr 0x005 with data 0xDEADBEEF, then a read from client 1 of 0x005 -> resp_val in the cycle after the read grant, resp_id=1, resp_data=0xDEADBEEF.
- Both clients read every cycle (c0 addr 0x010, c1 addr 0x020), resp_rdy=1 -> grants alternate 0,1,0,1, with one response per cycle and ids matching.
- Memory at 0x1FF = 0x11111111. In one cycle, client 0 reads 0x1FF and client 1 writes 0x22222222 to 0x1FF -> resp_data=0x22222222.
  - A later read of 0x1FF -> 0x22222222.
  - The same collision at different addresses -> old data is returned.
- Response stall: hold resp_rdy=0 for 4 cycles while client 0 keeps rd0_val=1 and a write to the read address lands -> resp_data stays constant and rd0_rdy=0 throughout.
  - Raising resp_rdy -> the held response retires and the next read is granted in the same cycle.
- Both clients write every cycle to distinct addresses -> wr grants alternate each cycle, and readback of all addresses matches the last granted data.
- Assert reset for one cycle while resp_val=1 -> the next cycle has resp_val=0, all rdy=0 during reset, and a contested read after reset is granted to client 0 first.

Source files
------------

// File: rtl/sram1r1w_arbiter.sv
// Two-client arbiter in front of a 1R1W SRAM macro. Reads and writes use independent round-robin pointers.
// Read data returns on one valid/ready channel, with same-cycle read/write collisions forwarded.
module sram1r1w_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd0_val,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_rdy,
  input  logic              rd1_val,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_rdy,
  input  logic              wr0_val,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_rdy,
  input  logic              wr1_val,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_rdy,
  output logic              resp_val,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  input  logic              resp_rdy,
  output logic [ADDR_W-1:0] sram_a1,
  output logic              sram_csb1,
  output logic              sram_oeb1,
  input  logic [DATA_W-1:0] sram_o1,
  output logic [ADDR_W-1:0] sram_a2,
  output logic              sram_csb2,
  output logic              sram_web2,
  output logic [DATA_W-1:0] sram_i2
);

  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              resp_val_q, resp_val_d;
  logic              resp_id_q, resp_id_d;
  logic              fwd_q, fwd_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  logic rd_en, rd_gnt, wr_gnt;

  // Pointer value 0 favours client 0; it flips only on a contested grant.
  always_comb begin
    rd_en      = ~reset & (~resp_val_q | resp_rdy);
    rd0_rdy    = rd_en & rd0_val & (~rd1_val | ~rd_ptr_q);
    rd1_rdy    = rd_en & rd1_val & (~rd0_val | rd_ptr_q);
    wr0_rdy    = ~reset & wr0_val & (~wr1_val | ~wr_ptr_q);
    wr1_rdy    = ~reset & wr1_val & (~wr0_val | wr_ptr_q);
    rd_gnt     = rd0_rdy | rd1_rdy;
    wr_gnt     = wr0_rdy | wr1_rdy;

    sram_a1    = rd1_rdy ? rd1_addr : rd0_addr;
    sram_csb1  = ~rd_gnt;
    sram_oeb1  = 1'b0;
    sram_a2    = wr1_rdy ? wr1_addr : wr0_addr;
    sram_i2    = wr1_rdy ? wr1_data : wr0_data;
    sram_csb2  = ~wr_gnt;
    sram_web2  = ~wr_gnt;

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    resp_val_d = rd_gnt | (resp_val_q & ~resp_rdy);
    resp_id_d  = resp_id_q;
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;

    if (rd_en & rd0_val & rd1_val) rd_ptr_d = ~rd_ptr_q;
    if (~reset & wr0_val & wr1_val) wr_ptr_d = ~wr_ptr_q;

    // The macro returns pre-write data on a same-address collision, so capture the write data.
    if (rd_gnt) begin
      resp_id_d  = rd1_rdy;
      fwd_d      = wr_gnt & (sram_a1 == sram_a2);
      fwd_data_d = sram_i2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      resp_val_q <= 1'b0;
      resp_id_q  <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      resp_val_q <= resp_val_d;
      resp_id_q  <= resp_id_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign resp_val  = resp_val_q;
  assign resp_id   = resp_id_q;
  assign resp_data = fwd_q ? fwd_data_q : sram_o1;

endmodule

// File: tb/tb_sram1r1w_arbiter.sv
// Self-checking bench for sram1r1w_arbiter: vector table with expected grants, plus a response scoreboard
// checked against a shadow memory and a behavioural 1R1W macro model.
module tb_sram1r1w_arbiter;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd0_val, rd1_val, wr0_val, wr1_val, resp_rdy;
  logic [AW-1:0] rd0_addr, rd1_addr, wr0_addr, wr1_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic          rd0_rdy, rd1_rdy, wr0_rdy, wr1_rdy;
  logic          resp_val, resp_id;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] sram_a1, sram_a2;
  logic          sram_csb1, sram_oeb1, sram_csb2, sram_web2;
  logic [DW-1:0] sram_o1, sram_i2;

  always #5 clk = ~clk;

  sram1r1w_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .rd0_val(rd0_val), .rd0_addr(rd0_addr), .rd0_rdy(rd0_rdy),
    .rd1_val(rd1_val), .rd1_addr(rd1_addr), .rd1_rdy(rd1_rdy),
    .wr0_val(wr0_val), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_rdy(wr0_rdy),
    .wr1_val(wr1_val), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_rdy(wr1_rdy),
    .resp_val(resp_val), .resp_id(resp_id), .resp_data(resp_data), .resp_rdy(resp_rdy),
    .sram_a1(sram_a1), .sram_csb1(sram_csb1), .sram_oeb1(sram_oeb1), .sram_o1(sram_o1),
    .sram_a2(sram_a2), .sram_csb2(sram_csb2), .sram_web2(sram_web2), .sram_i2(sram_i2)
  );

  // Macro model: registered read output returns pre-write contents on a same-edge collision.
  logic [DW-1:0] macro_mem [2**AW];
  always @(posedge clk) begin
    if (!sram_csb1) sram_o1 <= macro_mem[sram_a1];
    if (!sram_csb2 && !sram_web2) macro_mem[sram_a2] <= sram_i2;
  end

  typedef struct {
    logic          rst;
    logic          r0v;
    logic [AW-1:0] r0a;
    logic          r1v;
    logic [AW-1:0] r1a;
    logic          w0v;
    logic [AW-1:0] w0a;
    logic [DW-1:0] w0d;
    logic          w1v;
    logic [AW-1:0] w1a;
    logic [DW-1:0] w1d;
    logic          rrdy;
    logic [3:0]    eg;   // expected {wr1_rdy, wr0_rdy, rd1_rdy, rd0_rdy}
  } vec_t;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
  } sb_t;

  vec_t          tbl[$];
  sb_t           sb[$];
  logic [DW-1:0] shadow [2**AW];
  logic          m_rv;
  int            n_checks = 0;
  int            n_errors = 0;

  function automatic vec_t V(input logic rst, input logic r0v, input logic [AW-1:0] r0a,
                             input logic r1v, input logic [AW-1:0] r1a,
                             input logic w0v, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
                             input logic w1v, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
                             input logic rrdy, input logic [3:0] eg);
    vec_t v;
    v.rst = rst; v.r0v = r0v; v.r0a = r0a; v.r1v = r1v; v.r1a = r1a;
    v.w0v = w0v; v.w0a = w0a; v.w0d = w0d; v.w1v = w1v; v.w1a = w1a; v.w1d = w1d;
    v.rrdy = rrdy; v.eg = eg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    logic          rg, wg;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    sb_t           e;
    reset = v.rst;
    rd0_val = v.r0v; rd0_addr = v.r0a; rd1_val = v.r1v; rd1_addr = v.r1a;
    wr0_val = v.w0v; wr0_addr = v.w0a; wr0_data = v.w0d;
    wr1_val = v.w1v; wr1_addr = v.w1a; wr1_data = v.w1d;
    resp_rdy = v.rrdy;
    rg = v.eg[0] | v.eg[1];
    wg = v.eg[2] | v.eg[3];
    ra = v.eg[1] ? v.r1a : v.r0a;
    wa = v.eg[3] ? v.w1a : v.w0a;
    wd = v.eg[3] ? v.w1d : v.w0d;
    #4;
    chk("grants", 64'({wr1_rdy, wr0_rdy, rd1_rdy, rd0_rdy}), 64'(v.eg));
    chk("sram_ctl", 64'({sram_oeb1, sram_csb1, sram_csb2, sram_web2}), 64'({1'b0, ~rg, ~wg, ~wg}));
    if (rg) chk("sram_a1", 64'(sram_a1), 64'(ra));
    if (wg) chk("sram_a2_i2", 64'({sram_a2, sram_i2}), 64'({wa, wd}));
    chk("resp_val", 64'(resp_val), 64'(m_rv));
    if (m_rv) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
      else chk("resp_id_data", 64'({resp_id, resp_data}), 64'({sb[0].id, sb[0].data}));
    end
    if (v.rst) begin
      m_rv = 1'b0;
      sb.delete();
    end else begin
      if (m_rv && v.rrdy && sb.size() > 0) void'(sb.pop_front());
      if (rg) begin
        e.id   = v.eg[1];
        e.data = (wg && wa == ra) ? wd : shadow[ra];
        sb.push_back(e);
      end
      m_rv = rg | (m_rv & ~v.rrdy);
      if (wg) shadow[wa] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] rb [8];
    rb[0] = 9'h050; rb[1] = 9'h051; rb[2] = 9'h052; rb[3] = 9'h053;
    rb[4] = 9'h060; rb[5] = 9'h061; rb[6] = 9'h062; rb[7] = 9'h063;
    for (int i = 0; i < 2**AW; i++) begin
      macro_mem[i] = '0;
      shadow[i]    = '0;
    end
    m_rv = 1'b0;
    reset = 1'b1; resp_rdy = 1'b1;
    rd0_val = 0; rd1_val = 0; wr0_val = 0; wr1_val = 0;
    rd0_addr = '0; rd1_addr = '0; wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
    @(posedge clk);
    #1;

    // Reset, then write 0x005 from client 0 and read it back from client 1
    tbl.push_back(V(1, 1, 9'h000, 1, 9'h001, 1, 9'h002, 32'h1, 1, 9'h003, 32'h2, 1, 4'b0000));
    tbl.push_back(V(0, 0, 9'h000, 0, 9'h000, 1, 9'h005, 32'hDEADBEEF, 0, 9'h000, 32'h0, 1, 4'b0100));
    tbl.push_back(V(0, 0, 9'h000, 1, 9'h005, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0010));
    tbl.push_back(V(0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0000));
    // Contested reads alternate 0,1,0,1
    tbl.push_back(V(0, 1, 9'h010, 1, 9'h020, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0001));
    tbl.push_back(V(0, 1, 9'h010, 1, 9'h020, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0010));
    tbl.push_back(V(0, 1, 9'h010, 1, 9'h020, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0001));
    tbl.push_back(V(0, 1, 9'h010, 1, 9'h020, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0010));
    tbl.push_back(V(0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0000));
    // Same-address collision at 0x1FF forwards new data; later read sees it too
    tbl.push_back(V(0, 0, 9'h000, 0, 9'h000, 1, 9'h1FF, 32'h11111111, 0, 9'h000, 32'h0, 1, 4'b0100));
    tbl.push_back(V(0, 1, 9'h1FF, 0, 9'h000, 0, 9'h000, 32'h0, 1, 9'h1FF, 32'h22222222, 1, 4'b1001));
    tbl.push_back(V(0, 0, 9'h000, 1, 9'h1FF, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0010));
    // Read/write in the same cycle to different addresses returns old data
    tbl.push_back(V(0, 0, 9'h000, 0, 9'h000, 1, 9'h030, 32'h33333333, 0, 9'h000, 32'h0, 1, 4'b0100));
    tbl.push_back(V(0, 1, 9'h030, 0, 9'h000, 0, 9'h000, 32'h0, 1, 9'h031, 32'h44444444, 1, 4'b1001));
    tbl.push_back(V(0, 1, 9'h031, 0, 9'h000, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0001));
    tbl.push_back(V(0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0000));
    // Response stall for 4 cycles with writes landing on the read address
    tbl.push_back(V(0, 1, 9'h040, 0, 9'h000, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0001));
    for (int i = 0; i < 4; i++)
      tbl.push_back(V(0, 1, 9'h040, 0, 9'h000, 1, 9'h040, 32'h66660000 + 32'(i), 0, 9'h000, 32'h0, 0, 4'b0100));
    tbl.push_back(V(0, 1, 9'h040, 0, 9'h000, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0001));
    tbl.push_back(V(0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0000));
    // Contested writes alternate each cycle
    for (int i = 0; i < 4; i++)
      tbl.push_back(V(0, 0, 9'h000, 0, 9'h000, 1, 9'h050 + 9'(i), 32'hA0 + 32'(i),
                      1, 9'h060 + 9'(i), 32'hB0 + 32'(i), 1, (i % 2 == 0) ? 4'b0100 : 4'b1000));

    foreach (tbl[i]) apply(tbl[i]);

    // Readback of every address touched by the alternating writes
    for (int i = 0; i < 8; i++)
      apply(V(0, 1, rb[i], 0, 9'h000, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0001));
    apply(V(0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0000));

    // Contested grants move both pointers to client 1; reset with a response pending restores client 0
    apply(V(0, 1, 9'h050, 1, 9'h060, 1, 9'h070, 32'h77, 1, 9'h071, 32'h88, 1, 4'b0101));
    apply(V(1, 1, 9'h050, 1, 9'h060, 1, 9'h070, 32'h99, 1, 9'h071, 32'hAA, 0, 4'b0000));
    apply(V(0, 1, 9'h050, 1, 9'h060, 1, 9'h072, 32'hBB, 1, 9'h073, 32'hCC, 1, 4'b0101));
    apply(V(0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 32'h0, 0, 9'h000, 32'h0, 1, 4'b0000));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
